rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Parametrised N-port bus arbiter for the CPU bus fabric. It selects one requester per grant using fixed-priority or round-robin order. Grants can optionally be locked until the winner drops its request or acknowledges. It builds on the combinational `priority_encoder` and adds registered grants, rotating fairness state and grant-hold handshakes. Its outputs drive bus multiplexer selects and per-master grant lines.

## Interface
Parameters:
- `PORTS`, 4: number of requesters; legal range 2..32.
- `ARB_TYPE_ROUND_ROBIN`, 1: 1 = round-robin, 0 = fixed priority.
- `ARB_BLOCK`, 1: 1 = hold the grant while the release condition is unmet; 0 = re-arbitrate every cycle.
- `ARB_BLOCK_ACK`, 1: only meaningful when `ARB_BLOCK`=1. 1 = release on acknowledge; 0 = release when the granted request drops.
- `LSB_HIGH_PRIORITY`, 1: 1 = lower index wins ties and the round-robin base order is ascending; 0 = higher index wins and the order is descending.

Ports:
- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `request`  in  PORTS  per-port request.
- `acknowledge`  in  PORTS  per-port transfer-complete pulse; used only when `ARB_BLOCK_ACK`=1.
- `grant`  out  PORTS  one-hot grant, registered.
- `grant_valid`  out  1  high when `grant` is non-zero.
- `grant_encoded`  out  $clog2(PORTS)  index of the granted port; 0 when `grant_valid`=0.

## Operation
- Reset values: `grant`=0, `grant_valid`=0, `grant_encoded`=0. The round-robin mask resets so that port 0 is first when `LSB_HIGH_PRIORITY`=1, or port PORTS-1 is first when it is 0.
- Per-cycle decision has three cases:
  - HOLD: `ARB_BLOCK`=1, `grant_valid`=1 and the release condition is false. `grant` is unchanged.
  - ARBITRATE: any other cycle with a non-zero `request`. The next `grant` is the winner.
  - IDLE: not in HOLD and `request`=0. The next `grant` is 0.
- Release conditions:
  - `ARB_BLOCK_ACK`=0: `(request & grant)==0`.
  - `ARB_BLOCK_ACK`=1: `(acknowledge & grant)!=0`. The hold persists if the request drops without an acknowledge.
- Acknowledges on non-granted ports are ignored.
- Fixed priority: the winner is `priority_encoder(request)`.
- Round robin:
  - `mask` holds the ports strictly after the last winner in base order.
  - If `request & mask` is non-zero, the winner is the encoder output of `request & mask`; otherwise it is the encoder output of `request`. Wrap-around therefore falls back to the unmasked set.
  - `mask` updates only in a cycle that produces a new non-zero grant. A re-grant to the same port still updates `mask`.
- The release cycle and re-arbitration are the same cycle. When a HOLD releases, arbitration occurs in that cycle and the new winner appears at the next edge, so there are no dead cycles. The previous winner is excluded only by the mask.
- A request for the currently held port that is reasserted immediately after release is treated as a normal request.

## Timing
- Request to grant latency is 1 clock: a request sampled at edge k produces `grant` after edge k.
- `grant`, `grant_valid` and `grant_encoded` are all registered and change together. There are no combinational input-to-output paths.
- Asynchronous reset mid-hold forces all outputs to 0 immediately and restores the reset mask. The first edge after reset deassertion performs a normal arbitration.
- Without blocking (`ARB_BLOCK`=0), the grant may change every cycle.

## Structure
- Shared package `arbiter_pkg`: a function `clog2_min1(n)` returning max(1,$clog2(n)), and a function mapping one-hot to index. It is shared with the encoder.
- Sub-module: two instances of the existing `priority_encoder`, one for the masked request set and one for the unmasked set. The instances use `WIDTH`=`PORTS` and forward `LSB_HIGH_PRIORITY`.
- Top-level state: `grant_reg`, `grant_encoded_reg` and `mask_reg`.

## Test plan
All scenarios use `PORTS`=4 with `LSB_HIGH_PRIORITY`=1.
1. Reset and idle: hold `rst_n`=0, then release with `request`=0. Outputs stay 0 for 5 cycles.
2. Fixed priority (`ARB_TYPE_ROUND_ROBIN`=0, `ARB_BLOCK`=0): drive `request`=4'b1010. Next cycle `grant`=4'b0010 and `grant_encoded`=1; it stays there while the request is held.
3. Round robin (`ARB_BLOCK`=0): hold `request`=4'b1111. Grants cycle 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
4. Request-hold release (`ARB_BLOCK`=1, `ARB_BLOCK_ACK`=0):
   - `request`=4'b0011 gives `grant`=4'b0001, which is held.
   - Dropping request[0] gives `grant`=4'b0010 on the next edge.
5. Acknowledge release (`ARB_BLOCK_ACK`=1):
   - With `grant`=4'b0100, drop request[2] without an acknowledge. The grant is held.
   - `acknowledge`=4'b0001 is ignored.
   - `acknowledge`=4'b0100 releases; with `request`=4'b1001 the next grant is 4'b1000 (masked winner).
6. Asynchronous reset mid-hold: assert `rst_n`=0 between edges. Outputs go to 0 at once. After deassertion with `request`=4'b1111, the first grant is 4'b0001.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared helpers for the bus arbiter and its priority encoder.
package arbiter_pkg;

   // Per-cycle arbitration decision.
   typedef enum logic [1:0] {
      DEC_IDLE = 2'd0,
      DEC_ARB  = 2'd1,
      DEC_HOLD = 2'd2
   } arb_dec_e;

   // Index width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      int r;
      r = $clog2(n);
      return (r < 1) ? 1 : r;
   endfunction

   // One-hot to binary index; an all-zero vector maps to 0.
   function automatic logic [4:0] onehot_to_index(input logic [31:0] onehot);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (onehot[i]) idx = idx | 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder: picks the highest-priority set bit.
module priority_encoder
   import arbiter_pkg::*;
#(
   parameter int WIDTH             = 4,
   parameter bit LSB_HIGH_PRIORITY = 1,
   localparam int IW               = clog2_min1(WIDTH)
) (
   input  logic [WIDTH-1:0] input_unencoded,
   output logic             output_valid,
   output logic [IW-1:0]    output_encoded,
   output logic [WIDTH-1:0] output_unencoded
);

   // Scan in priority order and keep only the first set bit.
   always_comb begin
      logic found;
      int   idx;
      found            = 1'b0;
      idx              = 0;
      output_unencoded = '0;
      for (int k = 0; k < WIDTH; k++) begin
         idx = LSB_HIGH_PRIORITY ? k : (WIDTH - 1 - k);
         if (!found && input_unencoded[idx]) begin
            output_unencoded[idx] = 1'b1;
            found                 = 1'b1;
         end
      end
      output_valid   = |input_unencoded;
      output_encoded = IW'(onehot_to_index(32'(output_unencoded)));
   end

endmodule

// File: rtl/rr_arbiter.sv
// N-port bus arbiter: fixed-priority or round-robin, with optional grant hold
// released by request drop or by acknowledge. All outputs are registered.
module rr_arbiter
   import arbiter_pkg::*;
#(
   parameter int PORTS                = 4,
   parameter bit ARB_TYPE_ROUND_ROBIN = 1,
   parameter bit ARB_BLOCK            = 1,
   parameter bit ARB_BLOCK_ACK        = 1,
   parameter bit LSB_HIGH_PRIORITY    = 1,
   localparam int IW                  = clog2_min1(PORTS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PORTS-1:0] request,
   input  logic [PORTS-1:0] acknowledge,
   output logic [PORTS-1:0] grant,
   output logic             grant_valid,
   output logic [IW-1:0]    grant_encoded
);

   logic [PORTS-1:0] r_grant;
   logic             r_grant_valid;
   logic [IW-1:0]    r_grant_encoded;
   logic [PORTS-1:0] r_mask;

   logic [PORTS-1:0] w_masked_req;
   logic             w_masked_valid;
   logic [IW-1:0]    w_masked_idx;
   logic [PORTS-1:0] w_masked_oh;
   logic             w_req_valid;
   logic [IW-1:0]    w_req_idx;
   logic [PORTS-1:0] w_req_oh;

   logic             w_release;
   arb_dec_e         w_dec;
   logic [PORTS-1:0] w_win_oh;
   logic [IW-1:0]    w_win_idx;
   logic [PORTS-1:0] w_next_mask;

   assign w_masked_req = request & r_mask;

   priority_encoder #(
      .WIDTH            (PORTS),
      .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)
   ) u_enc_masked (
      .input_unencoded (w_masked_req),
      .output_valid    (w_masked_valid),
      .output_encoded  (w_masked_idx),
      .output_unencoded(w_masked_oh)
   );

   priority_encoder #(
      .WIDTH            (PORTS),
      .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)
   ) u_enc_req (
      .input_unencoded (request),
      .output_valid    (w_req_valid),
      .output_encoded  (w_req_idx),
      .output_unencoded(w_req_oh)
   );

   // Decide hold/arbitrate/idle and pick the winner; the mask wraps back to
   // the unmasked set once no request lies after the last winner.
   always_comb begin
      w_release = ARB_BLOCK_ACK ? (|(acknowledge & r_grant)) : ~(|(request & r_grant));
      if (ARB_BLOCK && r_grant_valid && !w_release) begin
         w_dec = DEC_HOLD;
      end else if (w_req_valid) begin
         w_dec = DEC_ARB;
      end else begin
         w_dec = DEC_IDLE;
      end

      if (ARB_TYPE_ROUND_ROBIN && w_masked_valid) begin
         w_win_oh  = w_masked_oh;
         w_win_idx = w_masked_idx;
      end else begin
         w_win_oh  = w_req_oh;
         w_win_idx = w_req_idx;
      end

      // Ports strictly after the winner in base order.
      if (LSB_HIGH_PRIORITY) begin
         w_next_mask = ~(w_win_oh | (w_win_oh - PORTS'(1)));
      end else begin
         w_next_mask = w_win_oh - PORTS'(1);
      end
   end

   // Grant, index and fairness mask registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant         <= '0;
         r_grant_valid   <= 1'b0;
         r_grant_encoded <= '0;
         r_mask          <= '1;
      end else begin
         case (w_dec)
            DEC_HOLD: begin
               r_grant         <= r_grant;
               r_grant_valid   <= r_grant_valid;
               r_grant_encoded <= r_grant_encoded;
            end
            DEC_ARB: begin
               r_grant         <= w_win_oh;
               r_grant_valid   <= 1'b1;
               r_grant_encoded <= w_win_idx;
               if (ARB_TYPE_ROUND_ROBIN) r_mask <= w_next_mask;
            end
            default: begin
               r_grant         <= '0;
               r_grant_valid   <= 1'b0;
               r_grant_encoded <= '0;
            end
         endcase
      end
   end

   assign grant         = r_grant;
   assign grant_valid   = r_grant_valid;
   assign grant_encoded = r_grant_encoded;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: four configurations driven from shared inputs, each
// checked against its own reference model through an expected-grant queue.
module tb_rr_arbiter;

   localparam int NCFG = 4;

   logic       clk         = 1'b0;
   logic       rst_n       = 1'b0;
   logic [3:0] request     = '0;
   logic [3:0] acknowledge = '0;

   logic [3:0] gnt  [NCFG];
   logic       gv   [NCFG];
   logic [1:0] genc [NCFG];

   int m_gnt  [NCFG];
   int m_last [NCFG];
   int q      [NCFG][$];
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // cfg0: RR, hold until ack
   rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
                .LSB_HIGH_PRIORITY(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
      .grant(gnt[0]), .grant_valid(gv[0]), .grant_encoded(genc[0]));
   // cfg1: RR, hold until request drops
   rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
                .LSB_HIGH_PRIORITY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
      .grant(gnt[1]), .grant_valid(gv[1]), .grant_encoded(genc[1]));
   // cfg2: fixed priority, no hold
   rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0),
                .LSB_HIGH_PRIORITY(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
      .grant(gnt[2]), .grant_valid(gv[2]), .grant_encoded(genc[2]));
   // cfg3: RR, no hold
   rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0),
                .LSB_HIGH_PRIORITY(1)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
      .grant(gnt[3]), .grant_valid(gv[3]), .grant_encoded(genc[3]));

   function automatic bit cfg_rr(input int c);
      return c != 2;
   endfunction

   function automatic bit cfg_blk(input int c);
      return c <= 1;
   endfunction

   function automatic bit cfg_ack(input int c);
      return c == 0;
   endfunction

   // Winner: lowest requested port for fixed priority; for round robin the
   // first requested port visited when walking upward from last winner + 1.
   function automatic int pick(input logic [3:0] req, input int last, input bit rr);
      int p;
      if (!rr) begin
         for (int i = 0; i < 4; i++) if (req[i]) return i;
         return -1;
      end
      for (int k = 1; k <= 4; k++) begin
         p = (last + k) % 4;
         if (req[p]) return p;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < NCFG; c++) begin
         m_gnt[c]  = -1;
         m_last[c] = -1;
      end
   endfunction

   function automatic void model_step(input logic [3:0] req, input logic [3:0] ack);
      bit hold;
      int w;
      for (int c = 0; c < NCFG; c++) begin
         hold = 1'b0;
         if (cfg_blk(c) && m_gnt[c] >= 0) begin
            if (cfg_ack(c)) hold = (ack[m_gnt[c]] == 1'b0);
            else            hold = (req[m_gnt[c]] == 1'b1);
         end
         if (!hold) begin
            w = pick(req, m_last[c], cfg_rr(c));
            m_gnt[c] = w;
            if (w >= 0) m_last[c] = w;
         end
         q[c].push_back(m_gnt[c]);
      end
   endfunction

   task automatic step(input logic [3:0] req, input logic [3:0] ack);
      @(negedge clk);
      request     = req;
      acknowledge = ack;
      model_step(req, ack);
   endtask

   // Monitor: after every edge, compare each DUT with its oldest expectation.
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         for (int c = 0; c < NCFG; c++) begin
            if (q[c].size() > 0) begin
               int         ei;
               logic [3:0] eg;
               logic       ev;
               logic [1:0] ee;
               ei = q[c].pop_front();
               eg = (ei >= 0) ? 4'(1 << ei) : 4'b0000;
               ev = (ei >= 0);
               ee = (ei >= 0) ? 2'(ei) : 2'd0;
               n_checks++;
               if (gnt[c] !== eg || gv[c] !== ev || genc[c] !== ee) begin
                  n_errors++;
                  $display("FAIL grant cfg%0d t=%0t: got grant=%b valid=%b enc=%0d, want grant=%b valid=%b enc=%0d",
                           c, $time, gnt[c], gv[c], genc[c], eg, ev, ee);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;

      // idle after reset
      repeat (5) step(4'b0000, 4'b0000);

      // fixed priority / first grants
      repeat (3) step(4'b1010, 4'b0000);

      // rotation with every grant acknowledged
      repeat (5) step(4'b1111, 4'b1111);
      repeat (2) step(4'b0000, 4'b1111);

      // request-drop release
      repeat (2) step(4'b0011, 4'b0000);
      repeat (2) step(4'b0010, 4'b0000);
      repeat (2) step(4'b0000, 4'b1111);

      // acknowledge release, stray ack ignored
      step(4'b0100, 4'b0000);
      step(4'b0000, 4'b0000);
      step(4'b0000, 4'b0001);
      step(4'b1001, 4'b0100);
      step(4'b1001, 4'b0000);

      // asynchronous reset in the middle of a hold
      repeat (2) step(4'b1111, 4'b0000);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      for (int c = 0; c < NCFG; c++) begin
         n_checks++;
         if (gnt[c] !== 4'b0000 || gv[c] !== 1'b0 || genc[c] !== 2'd0) begin
            n_errors++;
            $display("FAIL async_reset cfg%0d: got grant=%b valid=%b enc=%0d, want all zero",
                     c, gnt[c], gv[c], genc[c]);
         end
      end
      repeat (2) @(posedge clk);
      #3;
      model_reset();
      rst_n = 1'b1;
      repeat (3) step(4'b1111, 4'b0000);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
      end
      repeat (2) step(4'b0000, 4'b1111);

      @(posedge clk);
      #2;
      for (int c = 0; c < NCFG; c++) begin
         n_checks++;
         if (q[c].size() != 0) begin
            n_errors++;
            $display("FAIL drain cfg%0d: %0d expectations left, want 0", c, q[c].size());
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
